// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads opcode (+CB byte, +0..2 immediate bytes) at pc, requesting one pc_inc per consumed byte.
// Latency: one cycle per byte then a one-cycle instr_valid pulse; mem_ready=0 or cpu_en=0 stalls in place.
// Optional FETCH_ILLEGAL_TRAP_EN: traps the unused opcodes into a sticky illegal flag.
module instr_fetch_unit #(
  parameter logic [7:0] RESET_OPCODE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [15:0] pc,
  output logic        pc_inc,
  input  logic        fetch_start,
  input  logic        halt_bug,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  opcode,
  output logic        cb,
  output logic [15:0] imm,
  output logic [1:0]  imm_len,
  output logic        instr_valid,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_OP, S_CB_OP, S_IMM_LO, S_IMM_HI, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic        cb_q, cb_d;
  logic [15:0] imm_q, imm_d;
  logic [1:0]  imm_len_q, imm_len_d;
  logic        hb_q, hb_d;
  logic        illegal_q, illegal_d;
  logic        rd_state;

  function automatic logic [1:0] imm_bytes(input logic [7:0] op);
    case (op)
      8'h06, 8'h0E, 8'h10, 8'h16, 8'h18, 8'h1E, 8'h20, 8'h26, 8'h28,
      8'h2E, 8'h30, 8'h36, 8'h38, 8'h3E, 8'hC6, 8'hCE, 8'hD6, 8'hDE,
      8'hE0, 8'hE6, 8'hE8, 8'hEE, 8'hF0, 8'hF6, 8'hF8, 8'hFE: imm_bytes = 2'd1;
      8'h01, 8'h08, 8'h11, 8'h21, 8'h31, 8'hC2, 8'hC3, 8'hC4, 8'hCA,
      8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:       imm_bytes = 2'd2;
      default:                                                       imm_bytes = 2'd0;
    endcase
  endfunction

`ifdef FETCH_ILLEGAL_TRAP_EN
  function automatic logic is_illegal(input logic [7:0] op);
    case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: is_illegal = 1'b1;
      default:                           is_illegal = 1'b0;
    endcase
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      opcode_q  <= RESET_OPCODE;
      cb_q      <= 1'b0;
      imm_q     <= 16'h0000;
      imm_len_q <= 2'd0;
      hb_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else if (cpu_en) begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      cb_q      <= cb_d;
      imm_q     <= imm_d;
      imm_len_q <= imm_len_d;
      hb_q      <= hb_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    cb_d      = cb_q;
    imm_d     = imm_q;
    imm_len_d = imm_len_q;
    hb_d      = hb_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (fetch_start && !illegal_q) begin
          state_d   = S_OP;
          cb_d      = 1'b0;
          imm_d     = 16'h0000;
          imm_len_d = 2'd0;
        end
      end
      S_OP: if (mem_ready) begin
        opcode_d = mem_rdata;
        hb_d     = 1'b0;
        if (mem_rdata == 8'hCB) begin
          state_d = S_CB_OP;
          cb_d    = 1'b1;
        end else if (imm_bytes(mem_rdata) != 2'd0) begin
          state_d   = S_IMM_LO;
          imm_len_d = imm_bytes(mem_rdata);
        end else begin
          state_d = S_DONE;
`ifdef FETCH_ILLEGAL_TRAP_EN
          if (is_illegal(mem_rdata)) illegal_d = 1'b1;
`endif
        end
      end
      S_CB_OP: if (mem_ready) begin
        opcode_d = mem_rdata;
        state_d  = S_DONE;
      end
      S_IMM_LO: if (mem_ready) begin
        imm_d[7:0] = mem_rdata;
        state_d    = (imm_len_q == 2'd2) ? S_IMM_HI : S_DONE;
      end
      S_IMM_HI: if (mem_ready) begin
        imm_d[15:8] = mem_rdata;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // A halt_bug arriving alongside the OP byte still arms the following fetch.
    if (halt_bug) hb_d = 1'b1;
  end

  always_comb begin
    rd_state    = (state_q == S_OP) || (state_q == S_CB_OP) ||
                  (state_q == S_IMM_LO) || (state_q == S_IMM_HI);
    mem_rd      = rd_state;
    mem_addr    = pc;
    busy        = (state_q != S_IDLE);
    pc_inc      = !reset && cpu_en && mem_ready && rd_state &&
                  !((state_q == S_OP) && hb_q);
    instr_valid = !reset && cpu_en && (state_q == S_DONE);
    opcode      = opcode_q;
    cb          = cb_q;
    imm         = imm_q;
    imm_len     = imm_len_q;
    illegal     = illegal_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; a behavioural pc_register follows pc_inc.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, cpu_en, pc_inc, fetch_start, halt_bug, busy, mem_rd, mem_ready;
  logic        cb, instr_valid, illegal;
  logic [15:0] pc, mem_addr, imm;
  logic [7:0]  mem_rdata, opcode;
  logic [1:0]  imm_len;
  int          total = 0;
  int          passed = 0;
  int          fails = 0;

  instr_fetch_unit #(.RESET_OPCODE(8'h00)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .pc(pc), .pc_inc(pc_inc),
    .fetch_start(fetch_start), .halt_bug(halt_bug), .busy(busy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .opcode(opcode), .cb(cb), .imm(imm),
    .imm_len(imm_len), .instr_valid(instr_valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pc_inc) pc <= pc + 16'd1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input logic exp_inc, input string tag);
    mem_rdata = b;
    mem_ready = 1'b1;
    #1;
    chk({tag, "_pc_inc"}, 16'(pc_inc), 16'(exp_inc));
    chk({tag, "_mem_rd"}, 16'(mem_rd), 16'h1);
    chk({tag, "_addr"}, mem_addr, pc);
    tick();
  endtask

  initial begin
    reset = 1'b1; cpu_en = 1'b1; fetch_start = 1'b0; halt_bug = 1'b0;
    mem_ready = 1'b0; mem_rdata = 8'h00; pc = 16'h0000;
    tick(); tick();
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_valid", 16'(instr_valid), 16'h0);
    chk("rst_opcode", 16'(opcode), 16'h0000);
    reset = 1'b0;

    // NOP at 0x0100
    pc = 16'h0100;
    start();
    feed(8'h00, 1'b1, "nop");
    chk("nop_valid", 16'(instr_valid), 16'h1);
    chk("nop_opcode", 16'(opcode), 16'h0000);
    chk("nop_len", 16'(imm_len), 16'h0);
    chk("nop_pc", pc, 16'h0101);
    tick();
    chk("nop_idle", 16'(busy), 16'h0);

    // LD BC,d16 at 0x0150; fetch_start during IMM_LO must be ignored
    pc = 16'h0150;
    start();
    feed(8'h01, 1'b1, "ld_op");
    fetch_start = 1'b1;
    feed(8'h34, 1'b1, "ld_lo");
    fetch_start = 1'b0;
    chk("ld_in_hi", 16'(instr_valid), 16'h0);
    feed(8'h12, 1'b1, "ld_hi");
    chk("ld_valid", 16'(instr_valid), 16'h1);
    chk("ld_imm", imm, 16'h1234);
    chk("ld_len", 16'(imm_len), 16'h2);
    chk("ld_opcode", 16'(opcode), 16'h0001);
    chk("ld_pc", pc, 16'h0153);
    tick();
    chk("ld_valid_once", 16'(instr_valid), 16'h0);

    // CB 37, then back-to-back JR 0xFE
    pc = 16'h0160;
    start();
    feed(8'hCB, 1'b1, "cb_pre");
    feed(8'h37, 1'b1, "cb_op");
    chk("cb_valid", 16'(instr_valid), 16'h1);
    chk("cb_flag", 16'(cb), 16'h1);
    chk("cb_opcode", 16'(opcode), 16'h0037);
    chk("cb_len", 16'(imm_len), 16'h0);
    chk("cb_pc", pc, 16'h0162);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("b2b_cb_clr", 16'(cb), 16'h0);
    feed(8'h18, 1'b1, "jr_op");
    feed(8'hFE, 1'b1, "jr_imm");
    chk("jr_valid", 16'(instr_valid), 16'h1);
    chk("jr_imm", imm, 16'h00FE);
    chk("jr_len", 16'(imm_len), 16'h1);
    chk("jr_pc", pc, 16'h0164);
    tick();

    // HALT bug: opcode byte consumed without pc_inc
    pc = 16'h0200;
    halt_bug = 1'b1;
    tick();
    halt_bug = 1'b0;
    start();
    feed(8'h3E, 1'b0, "hb_op");
    feed(8'h05, 1'b1, "hb_imm");
    chk("hb_valid", 16'(instr_valid), 16'h1);
    chk("hb_opcode", 16'(opcode), 16'h003E);
    chk("hb_imm", imm, 16'h0005);
    chk("hb_pc", pc, 16'h0201);
    tick();
    start();
    feed(8'h00, 1'b1, "hb_cleared");
    tick();

    // stalls in IMM_HI: mem_ready low, then cpu_en low
    pc = 16'h0300;
    start();
    feed(8'h01, 1'b1, "st_op");
    feed(8'hAA, 1'b1, "st_lo");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_nordy_inc", 16'(pc_inc), 16'h0);
      tick();
      chk("st_nordy_busy", 16'(busy), 16'h1);
    end
    cpu_en = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("st_cpuen_inc", 16'(pc_inc), 16'h0);
    chk("st_cpuen_rd", 16'(mem_rd), 16'h1);
    tick();
    chk("st_cpuen_valid", 16'(instr_valid), 16'h0);
    chk("st_pc_held", pc, 16'h0302);
    cpu_en = 1'b1;
    feed(8'hBB, 1'b1, "st_hi");
    chk("st_valid", 16'(instr_valid), 16'h1);
    chk("st_imm", imm, 16'hBBAA);
    chk("st_pc", pc, 16'h0303);
    tick();

    // reset mid IMM_LO
    pc = 16'h0400;
    start();
    feed(8'h21, 1'b1, "rm_op");
    reset = 1'b1;
    mem_rdata = 8'h99;
    mem_ready = 1'b1;
    #1;
    chk("rm_no_inc", 16'(pc_inc), 16'h0);
    tick();
    reset = 1'b0;
    chk("rm_busy", 16'(busy), 16'h0);
    chk("rm_rd", 16'(mem_rd), 16'h0);
    chk("rm_opcode", 16'(opcode), 16'h0000);
    chk("rm_imm", imm, 16'h0000);
    chk("rm_len", 16'(imm_len), 16'h0);
    chk("rm_valid", 16'(instr_valid), 16'h0);
    chk("rm_illegal", 16'(illegal), 16'h0);
    chk("rm_pc", pc, 16'h0401);

    // illegal opcode D3
    pc = 16'h0500;
    start();
    feed(8'hD3, 1'b1, "il_op");
    chk("il_valid", 16'(instr_valid), 16'h1);
    chk("il_len", 16'(imm_len), 16'h0);
    tick();
`ifdef FETCH_ILLEGAL_TRAP_EN
    chk("il_flag", 16'(illegal), 16'h1);
    fetch_start = 1'b1;
    tick();
    tick();
    fetch_start = 1'b0;
    chk("il_ignored", 16'(busy), 16'h0);
    chk("il_sticky", 16'(illegal), 16'h1);
`else
    chk("il_flag", 16'(illegal), 16'h0);
    start();
    chk("il_next_busy", 16'(busy), 16'h1);
    feed(8'h00, 1'b1, "il_next");
    chk("il_next_valid", 16'(instr_valid), 16'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
